// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-drain UART transmitter: FSM encoding,
// line levels and a small helper used by the top-level decode.
package fifo_uart_tx_pkg;

    // Frame sequencing states; any other encoding falls back to ST_IDLE.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } state_t;

    // Serial line levels.
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    // True while a serial bit is on the line (the bit timer must run).
    function automatic logic is_bit_state(input state_t s);
        return (s == ST_START) || (s == ST_DATA) ||
               (s == ST_PARITY) || (s == ST_STOP);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last
// cycle of each bit. restart holds the count at zero so every frame starts
// from a clean bit boundary.
module fifo_uart_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign tick = !restart && (count == LAST);

    // Free-running bit counter, reloaded on each bit boundary or restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (restart || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drain stage for the FIFO: pops one byte whenever the FIFO is non-empty and
// enabled, then shifts it out as start, LSB-first data, optional even parity
// and one stop bit. All outputs are decoded from registered state only.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  pop,
    output logic                  tx,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    state_t                state;
    state_t                next_state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [BCW-1:0]        bit_cnt;
    logic                  parity_q;
    logic                  tick;
    logic                  timer_restart;

    // The timer idles at zero outside the serial bit states.
    assign timer_restart = !is_bit_state(state);

    fifo_uart_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .restart(timer_restart),
        .tick   (tick)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; empty and en are only looked at in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (en && !empty) next_state = ST_POP;
            ST_POP:    next_state = ST_LOAD;
            ST_LOAD:   next_state = ST_START;
            ST_START:  if (tick) next_state = ST_DATA;
            ST_DATA: begin
                if (tick && (bit_cnt == LAST_BIT)) begin
                    next_state = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (tick) next_state = ST_STOP;
            ST_STOP:   if (tick) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Moore output decode from the state register and datapath registers.
    always_comb begin
        pop  = (state == ST_POP);
        busy = (state != ST_IDLE);
        tx   = LINE_IDLE;
        case (state)
            ST_START:  tx = LINE_START;
            ST_DATA:   tx = shift_reg[0];
            ST_PARITY: tx = parity_q;
            ST_STOP:   tx = LINE_STOP;
            default:   tx = LINE_IDLE;
        endcase
    end

    // Payload capture in LOAD (FIFO data is valid the cycle after pop),
    // then one right shift per completed data bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            parity_q  <= 1'b0;
        end else if (state == ST_LOAD) begin
            shift_reg <= fifo_data;
            bit_cnt   <= '0;
            parity_q  <= ^fifo_data;
        end else if ((state == ST_DATA) && tick) begin
            shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
            bit_cnt   <= bit_cnt + BCW'(1);
        end
    end

    // Completed-frame counter, bumped on the last cycle of the stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 16'd0;
        end else if ((state == ST_STOP) && tick) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (parity off / even parity on), each
// fed by a FIFO model with registered data_out and watched by a line decoder.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic        clk;
    logic        rst;
    logic        en;

    logic        empty0, empty1;
    logic [7:0]  fd0, fd1;
    logic        pop0, pop1;
    logic        tx0, tx1;
    logic        busy0, busy1;
    logic [15:0] frame_cnt0, frame_cnt1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // FIFO models: pushes from the test process, pops from the DUT.
    logic [7:0] mem0 [0:255];
    logic [7:0] mem1 [0:255];
    int pushed0 = 0, popped0 = 0, pushed1 = 0, popped1 = 0;
    int pop_cnt0 = 0, pop_cnt1 = 0, bad_pop0 = 0, bad_pop1 = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int         start_q0[$];
    int         start_q1[$];
    logic       par_q1[$];

    assign empty0 = (pushed0 == popped0);
    assign empty1 = (pushed1 == popped1);

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .empty(empty0), .fifo_data(fd0),
        .pop(pop0), .tx(tx0), .busy(busy0), .frame_cnt(frame_cnt0)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .empty(empty1), .fifo_data(fd1),
        .pop(pop1), .tx(tx1), .busy(busy1), .frame_cnt(frame_cnt1)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model with registered read data.
    always @(posedge clk) begin
        if (pop0) begin
            pop_cnt0 <= pop_cnt0 + 1;
            if (empty0) bad_pop0 <= bad_pop0 + 1;
            else begin
                fd0     <= mem0[popped0 % 256];
                popped0 <= popped0 + 1;
            end
        end
        if (pop1) begin
            pop_cnt1 <= pop_cnt1 + 1;
            if (empty1) bad_pop1 <= bad_pop1 + 1;
            else begin
                fd1     <= mem1[popped1 % 256];
                popped1 <= popped1 + 1;
            end
        end
    end

    function automatic logic get_tx(input int idx);
        return (idx == 0) ? tx0 : tx1;
    endfunction

    function automatic int get_fc(input int idx);
        return (idx == 0) ? int'(frame_cnt0) : int'(frame_cnt1);
    endfunction

    task automatic push(input int idx, input logic [7:0] d);
        if (idx == 0) begin
            mem0[pushed0 % 256] = d;
            pushed0++;
            exp_q0.push_back(d);
        end else begin
            mem1[pushed1 % 256] = d;
            pushed1++;
            exp_q1.push_back(d);
        end
    endtask

    // Line decoder / scoreboard: samples mid-bit, aborts on reset.
    task automatic monitor(input int idx);
        logic       prev, t, b, p_bit;
        logic [7:0] val, e;
        int         nb, bi;
        bit         abort;
        nb   = (idx == 0) ? 10 : 11;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            t = get_tx(idx);
            if (!rst && prev === 1'b1 && t === 1'b0) begin
                if (idx == 0) start_q0.push_back(cyc);
                else          start_q1.push_back(cyc);
                abort = 0; val = '0; p_bit = 1'b0;
                for (int k = 1; k < nb * CPB; k++) begin
                    @(negedge clk);
                    if (rst) begin abort = 1; break; end
                    if (k % CPB == CPB / 2) begin
                        b  = get_tx(idx);
                        bi = k / CPB;
                        if (bi == 0) begin
                            total++;
                            if (b !== 1'b0) begin
                                bad++;
                                $display("FAIL start_bit%0d: got %b expected 0", idx, b);
                            end
                        end else if (bi <= 8) begin
                            val[bi-1] = b;
                        end else if (idx == 1 && bi == 9) begin
                            p_bit = b;
                        end else begin
                            total++;
                            if (b !== 1'b1) begin
                                bad++;
                                $display("FAIL stop_bit%0d: got %b expected 1", idx, b);
                            end
                        end
                    end
                end
                if (!abort) begin
                    total++;
                    if ((idx == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        bad++;
                        $display("FAIL unexpected_frame%0d: got %h expected none", idx, val);
                    end else begin
                        e = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        if (val !== e) begin
                            bad++;
                            $display("FAIL frame_byte%0d: got %h expected %h", idx, val, e);
                        end
                        if (idx == 1) begin
                            par_q1.push_back(p_bit);
                            total++;
                            if (p_bit !== ^e) begin
                                bad++;
                                $display("FAIL parity_bit: got %b expected %b", p_bit, ^e);
                            end
                        end
                    end
                end
                t = get_tx(idx);
            end
            prev = t;
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    // Bounded wait for an instance's frame counter to reach target.
    task automatic wait_fc(input int idx, input int target, input int budget,
                           output bit ok, output int at_cyc);
        ok = 0; at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (get_fc(idx) == target) begin ok = 1; at_cyc = cyc; break; end
        end
    endtask

    task automatic test_reset();
        bit tx_low;
        rst = 1'b1; en = 1'b0;
        repeat (3) @(negedge clk);
        total += 5;
        if (tx0 !== 1'b1)         begin bad++; $display("FAIL reset_tx: got %b expected 1", tx0); end
        if (pop0 !== 1'b0)        begin bad++; $display("FAIL reset_pop: got %b expected 0", pop0); end
        if (busy0 !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        if (frame_cnt0 !== 16'd0) begin bad++; $display("FAIL reset_fc: got %0d expected 0", frame_cnt0); end
        if (tx1 !== 1'b1 || busy1 !== 1'b0 || frame_cnt1 !== 16'd0) begin
            bad++; $display("FAIL reset_par_inst: got tx=%b busy=%b fc=%0d expected 1 0 0", tx1, busy1, frame_cnt1);
        end
        rst = 1'b0; en = 1'b1;
        tx_low = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || tx1 !== 1'b1) tx_low = 1;
        end
        total += 2;
        if (pop_cnt0 + pop_cnt1 != 0) begin bad++; $display("FAIL empty_no_pop: got %0d expected 0", pop_cnt0 + pop_cnt1); end
        if (tx_low)                   begin bad++; $display("FAIL empty_tx_idle: got low expected high"); end
    endtask

    task automatic test_single();
        int c, p0, done; bit ok;
        start_q0.delete();
        p0 = pop_cnt0;
        @(negedge clk);
        push(0, 8'hA5);
        c = cyc;
        wait_fc(0, 1, 100, ok, done);
        total += 5;
        if (!ok) begin bad++; $display("FAIL single_timeout: got fc=%0d expected 1", frame_cnt0); end
        if (pop_cnt0 - p0 != 1) begin bad++; $display("FAIL single_pops: got %0d expected 1", pop_cnt0 - p0); end
        if (start_q0.size() < 1 || start_q0[0] - c != 3) begin
            bad++; $display("FAIL single_latency: got %0d expected 3", (start_q0.size() > 0) ? start_q0[0] - c : -1);
        end
        if (done - c != 43) begin bad++; $display("FAIL single_length: got %0d expected 43", done - c); end
        if (frame_cnt0 !== 16'd1) begin bad++; $display("FAIL single_fc: got %0d expected 1", frame_cnt0); end
    endtask

    task automatic test_back_to_back();
        int p0, done; bit ok;
        start_q0.delete();
        p0 = pop_cnt0;
        @(negedge clk);
        push(0, 8'h00); push(0, 8'hFF); push(0, 8'h55);
        wait_fc(0, 4, 300, ok, done);
        total += 4;
        if (!ok) begin bad++; $display("FAIL b2b_timeout: got fc=%0d expected 4", frame_cnt0); end
        if (pop_cnt0 - p0 != 3) begin bad++; $display("FAIL b2b_pops: got %0d expected 3", pop_cnt0 - p0); end
        if (start_q0.size() != 3) begin
            bad++; $display("FAIL b2b_frames: got %0d expected 3", start_q0.size());
        end else begin
            if (start_q0[1] - start_q0[0] != 43 || start_q0[2] - start_q0[1] != 43) begin
                bad++; $display("FAIL b2b_gap: got %0d,%0d expected 43,43", start_q0[1] - start_q0[0], start_q0[2] - start_q0[1]);
            end
        end
        if (frame_cnt0 !== 16'd4) begin bad++; $display("FAIL b2b_fc: got %0d expected 4", frame_cnt0); end
    endtask

    task automatic test_parity();
        int done; bit ok;
        start_q1.delete(); par_q1.delete();
        @(negedge clk);
        push(1, 8'h07); push(1, 8'h03);
        wait_fc(1, 2, 200, ok, done);
        total += 4;
        if (!ok) begin bad++; $display("FAIL par_timeout: got fc=%0d expected 2", frame_cnt1); end
        if (par_q1.size() != 2 || par_q1[0] !== 1'b1 || par_q1[1] !== 1'b0) begin
            bad++; $display("FAIL par_bits: got n=%0d expected bits 1,0", par_q1.size());
        end
        if (start_q1.size() != 2 || start_q1[1] - start_q1[0] != 47) begin
            bad++; $display("FAIL par_length: got %0d expected 47", (start_q1.size() == 2) ? start_q1[1] - start_q1[0] : -1);
        end
        if (frame_cnt1 !== 16'd2) begin bad++; $display("FAIL par_fc: got %0d expected 2", frame_cnt1); end
    endtask

    task automatic test_reset_mid();
        int s, p0, done, guard; bit ok;
        start_q0.delete();
        @(negedge clk);
        push(0, 8'hC3);
        guard = 0;
        while (start_q0.size() == 0 && guard < 50) begin @(negedge clk); guard++; end
        total++;
        if (start_q0.size() == 0) begin
            bad++; $display("FAIL rmid_no_start: got none expected start");
        end else begin
            s = start_q0[0];
            while (cyc < s + 17) @(negedge clk);
            total++;
            if (tx0 !== 1'b0) begin bad++; $display("FAIL rmid_bit3: got %b expected 0", tx0); end
            rst = 1'b1;
            #1;
            total += 3;
            if (tx0 !== 1'b1)         begin bad++; $display("FAIL rmid_tx: got %b expected 1", tx0); end
            if (busy0 !== 1'b0)       begin bad++; $display("FAIL rmid_busy: got %b expected 0", busy0); end
            if (frame_cnt0 !== 16'd0) begin bad++; $display("FAIL rmid_fc: got %0d expected 0", frame_cnt0); end
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        exp_q0.delete();
        rst = 1'b0;
        p0 = pop_cnt0;
        push(0, 8'h3C);
        wait_fc(0, 1, 100, ok, done);
        total += 2;
        if (!ok || frame_cnt0 !== 16'd1) begin bad++; $display("FAIL rmid_after_fc: got %0d expected 1", frame_cnt0); end
        if (pop_cnt0 - p0 != 1) begin bad++; $display("FAIL rmid_after_pops: got %0d expected 1", pop_cnt0 - p0); end
    endtask

    task automatic test_en_drop();
        int f, p0, done, guard; bit ok;
        f  = frame_cnt0;
        p0 = pop_cnt0;
        @(negedge clk);
        push(0, 8'h96); push(0, 8'h4B);
        guard = 0;
        while (!busy0 && guard < 20) begin @(negedge clk); guard++; end
        en = 1'b0;
        wait_fc(0, f + 1, 100, ok, done);
        repeat (60) @(negedge clk);
        total += 3;
        if (!ok || frame_cnt0 != 16'(f + 1)) begin bad++; $display("FAIL endrop_fc: got %0d expected %0d", frame_cnt0, f + 1); end
        if (pop_cnt0 - p0 != 1) begin bad++; $display("FAIL endrop_pops: got %0d expected 1", pop_cnt0 - p0); end
        if (busy0 !== 1'b0) begin bad++; $display("FAIL endrop_busy: got %b expected 0", busy0); end
        en = 1'b1;
        wait_fc(0, f + 2, 100, ok, done);
        total += 2;
        if (!ok) begin bad++; $display("FAIL enrise_fc: got %0d expected %0d", frame_cnt0, f + 2); end
        if (pop_cnt0 - p0 != 2) begin bad++; $display("FAIL enrise_pops: got %0d expected 2", pop_cnt0 - p0); end
    endtask

    task automatic test_random();
        int f0, f1, d0, d1; bit ok0, ok1;
        f0 = frame_cnt0; f1 = frame_cnt1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            push(0, 8'($urandom_range(0, 255)));
            push(1, 8'($urandom_range(0, 255)));
        end
        wait_fc(0, f0 + 4, 400, ok0, d0);
        wait_fc(1, f1 + 4, 400, ok1, d1);
        total += 2;
        if (!ok0) begin bad++; $display("FAIL random_fc0: got %0d expected %0d", frame_cnt0, f0 + 4); end
        if (!ok1) begin bad++; $display("FAIL random_fc1: got %0d expected %0d", frame_cnt1, f1 + 4); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_reset_mid();
        test_en_drop();
        test_random();
        repeat (5) @(negedge clk);
        total += 2;
        if (exp_q0.size() + exp_q1.size() != 0) begin
            bad++; $display("FAIL leftover_bytes: got %0d expected 0", exp_q0.size() + exp_q1.size());
        end
        if (bad_pop0 + bad_pop1 != 0) begin
            bad++; $display("FAIL pop_while_empty: got %0d expected 0", bad_pop0 + bad_pop1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
